// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the uart_tx arbiter slice.
package uart_arb_pkg;

  localparam int unsigned UART_DATA_W = 8;
  localparam int unsigned BYTES_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle between the byte producers, the arbiter and uart_tx.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import uart_arb_pkg::*;

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*UART_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           uart_tx_busy;
  logic                           uart_tx_en;
  logic [UART_DATA_W-1:0]         uart_tx_data;
  logic [ID_W-1:0]                grant_id;
  logic                           grant_active;
  logic                           tx_stall_err;
  logic [BYTES_CNT_W-1:0]         bytes_sent;

  // Environment side: requesters plus the transmitter busy line.
  modport master (
    output req_valid, req_data, req_last, uart_tx_busy,
    input  req_ready, uart_tx_en, uart_tx_data, grant_id, grant_active,
           tx_stall_err, bytes_sent
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_last, uart_tx_busy,
    output req_ready, uart_tx_en, uart_tx_data, grant_id, grant_active,
           tx_stall_err, bytes_sent
  );

endinterface

// File: rtl/uart_rr_picker.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping.
module uart_rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic [$clog2(NUM_REQ)-1:0] idx_c,
  output logic                       any_c
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] cand;

  // Scan requesters starting at the pointer; the first one found wins.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!any_c && req[cand]) begin
        grant_c[cand] = 1'b1;
        idx_c         = cand;
        any_c         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NUM_REQ byte producers.
// Optional frame locking (hold the grant until req_last) under UART_ARB_FRAME_LOCK_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned BUSY_WAIT_CYC = 4
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(BUSY_WAIT_CYC + 1);

  state_t                 state, state_nxt;
  logic [ID_W-1:0]        rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]       wait_cnt, wait_cnt_nxt;
  logic [UART_DATA_W-1:0] data_nxt;
  logic [ID_W-1:0]        grant_id_nxt;
  logic                   stall_nxt;
  logic [BYTES_CNT_W-1:0] bytes_nxt;

  logic [NUM_REQ-1:0]     elig_c;
  logic [NUM_REQ-1:0]     pick_grant_c;
  logic [ID_W-1:0]        pick_idx_c;
  logic [ID_W-1:0]        pick_next_c;
  logic                   pick_any_c;

`ifdef UART_ARB_FRAME_LOCK_EN
  logic lock, lock_nxt;

  // While a frame is open only its owner (held in grant_id) may compete.
  assign elig_c = lock ? (bus.req_valid & (NUM_REQ'(1) << bus.grant_id)) : bus.req_valid;
`else
  logic unused_last;

  // Frame boundaries are irrelevant when arbitrating per byte.
  assign elig_c      = bus.req_valid;
  assign unused_last = ^bus.req_last;
`endif

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req     (elig_c),
    .ptr     (rr_ptr),
    .grant_c (pick_grant_c),
    .idx_c   (pick_idx_c),
    .any_c   (pick_any_c)
  );

  // Pointer value after granting pick_idx_c, wrapping for non-power-of-two counts.
  assign pick_next_c = (pick_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx_c + ID_W'(1);

  // Next-state, handshake and bookkeeping decode.
  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    wait_cnt_nxt  = wait_cnt;
    data_nxt      = bus.uart_tx_data;
    grant_id_nxt  = bus.grant_id;
    stall_nxt     = bus.tx_stall_err;
    bytes_nxt     = bus.bytes_sent;
    bus.req_ready = '0;
`ifdef UART_ARB_FRAME_LOCK_EN
    lock_nxt      = lock;
`endif
    case (state)
      IDLE: begin
        if (!bus.uart_tx_busy) begin
          bus.req_ready = pick_grant_c;
          if (pick_any_c) begin
            data_nxt     = bus.req_data[UART_DATA_W*32'(pick_idx_c) +: UART_DATA_W];
            grant_id_nxt = pick_idx_c;
            rr_ptr_nxt   = pick_next_c;
`ifdef UART_ARB_FRAME_LOCK_EN
            lock_nxt     = !bus.req_last[pick_idx_c];
`endif
            state_nxt    = ISSUE;
          end
        end
      end
      ISSUE: begin
        bytes_nxt    = bus.bytes_sent + BYTES_CNT_W'(1);
        wait_cnt_nxt = '0;
        state_nxt    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.uart_tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt == CNT_W'(BUSY_WAIT_CYC - 1)) begin
          stall_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.uart_tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; enable and activity flag follow the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      wait_cnt         <= '0;
      bus.uart_tx_en   <= 1'b0;
      bus.uart_tx_data <= '0;
      bus.grant_id     <= '0;
      bus.grant_active <= 1'b0;
      bus.tx_stall_err <= 1'b0;
      bus.bytes_sent   <= '0;
`ifdef UART_ARB_FRAME_LOCK_EN
      lock             <= 1'b0;
`endif
    end else begin
      state            <= state_nxt;
      rr_ptr           <= rr_ptr_nxt;
      wait_cnt         <= wait_cnt_nxt;
      bus.uart_tx_en   <= (state_nxt == ISSUE);
      bus.uart_tx_data <= data_nxt;
      bus.grant_id     <= grant_id_nxt;
      bus.grant_active <= (state_nxt != IDLE);
      bus.tx_stall_err <= stall_nxt;
      bus.bytes_sent   <= bytes_nxt;
`ifdef UART_ARB_FRAME_LOCK_EN
      lock             <= lock_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx busy model.
module tb_uart_tx_arbiter;
  localparam int unsigned NUM_REQ = 4;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [7:0]  bval;
    logic [1:0]  id;
    logic [15:0] cnt;
  } vec_t;

  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic model_on   = 1'b1;
  logic busy_force = 1'b0;
  int   busy_len   = 100;
  int   b_wait     = 0;
  int   b_left     = 0;
  int   cyc        = 0;
  int   tests      = 0;
  int   fails      = 0;

  logic [1:0] q_id[$];
  logic [7:0] q_data[$];
  int         q_cyc[$];

  vec_t tbl[8];

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_WAIT_CYC(4)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.uart_tx_busy = (b_left > 0) | busy_force;

  // Transmitter model: busy rises two cycles after en and lasts busy_len cycles; also logs every en.
  always @(negedge clk) begin
    if (bus.uart_tx_en) begin
      q_id.push_back(bus.grant_id);
      q_data.push_back(bus.uart_tx_data);
      q_cyc.push_back(cyc);
      if (model_on) b_wait = 2;
    end else if (b_wait > 0) begin
      b_wait = b_wait - 1;
      if (b_wait == 0) b_left = busy_len;
    end else if (b_left > 0) begin
      b_left = b_left - 1;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One byte through the arbiter from an idle start, back to idle.
  task automatic do_xfer(input logic [3:0] valid, input logic [3:0] exp_ready,
                         input logic [7:0] exp_byte, input logic [1:0] exp_id,
                         input logic [15:0] exp_cnt, input string tag);
    int n;
    step();
    bus.req_valid = valid;
    #1;
    chk({tag, " ready"}, 32'(bus.req_ready), 32'(exp_ready));
    step();
    bus.req_valid = '0;
    chk({tag, " en"}, 32'(bus.uart_tx_en), 32'd1);
    chk({tag, " data"}, 32'(bus.uart_tx_data), 32'(exp_byte));
    chk({tag, " id"}, 32'(bus.grant_id), 32'(exp_id));
    chk({tag, " active"}, 32'(bus.grant_active), 32'd1);
    n = 0;
    while ((bus.grant_active || bus.uart_tx_busy) && n < 400) begin
      step();
      n++;
    end
    chk({tag, " done"}, 32'(n < 400), 32'd1);
    chk({tag, " bytes"}, 32'(bus.bytes_sent), 32'(exp_cnt));
  endtask

  initial begin
    int  n;
    int  qs;
    int  cnt2;
    logic pend2;
    logic bad;

    tbl[0] = '{4'b1111, 4'b0100, 8'h12, 2'd2, 16'd2};
    tbl[1] = '{4'b0011, 4'b0001, 8'h10, 2'd0, 16'd3};
    tbl[2] = '{4'b1000, 4'b1000, 8'h13, 2'd3, 16'd4};
    tbl[3] = '{4'b0110, 4'b0010, 8'h11, 2'd1, 16'd5};
    tbl[4] = '{4'b0001, 4'b0001, 8'h10, 2'd0, 16'd6};
    tbl[5] = '{4'b1010, 4'b0010, 8'h11, 2'd1, 16'd7};
    tbl[6] = '{4'b1011, 4'b1000, 8'h13, 2'd3, 16'd8};
    tbl[7] = '{4'b1111, 4'b0001, 8'h10, 2'd0, 16'd9};

    bus.req_valid = '0;
    bus.req_data  = 32'h1312_1110;
    bus.req_last  = '1;

    // Reset values.
    repeat (3) step();
    chk("rst en", 32'(bus.uart_tx_en), 32'd0);
    chk("rst data", 32'(bus.uart_tx_data), 32'd0);
    chk("rst id", 32'(bus.grant_id), 32'd0);
    chk("rst active", 32'(bus.grant_active), 32'd0);
    chk("rst stall", 32'(bus.tx_stall_err), 32'd0);
    chk("rst bytes", 32'(bus.bytes_sent), 32'd0);
    rst = 1'b0;

    // Single requester with a long busy window.
    busy_len = 100;
    bus.req_data[15:8] = 8'hA5;
    do_xfer(4'b0010, 4'b0010, 8'hA5, 2'd1, 16'd1, "single");
    bus.req_data = 32'h1312_1110;

    // Round-robin table.
    busy_len = 3;
    for (int i = 0; i < 8; i++) begin
      do_xfer(tbl[i].valid, tbl[i].ready, tbl[i].bval, tbl[i].id, tbl[i].cnt, $sformatf("vec%0d", i));
    end

    // Busy never rises: stall flagged after four WAIT_BUSY cycles.
    model_on = 1'b0;
    step();
    bus.req_valid = 4'b0010;
    #1;
    chk("stall ready", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid = '0;
    chk("stall en", 32'(bus.uart_tx_en), 32'd1);
    repeat (4) step();
    chk("stall early", 32'(bus.tx_stall_err), 32'd0);
    chk("stall waiting", 32'(bus.grant_active), 32'd1);
    step();
    chk("stall set", 32'(bus.tx_stall_err), 32'd1);
    chk("stall idle", 32'(bus.grant_active), 32'd0);
    chk("stall bytes", 32'(bus.bytes_sent), 32'd10);
    model_on = 1'b1;
    do_xfer(4'b0100, 4'b0100, 8'h12, 2'd2, 16'd11, "after stall");
    chk("stall sticky", 32'(bus.tx_stall_err), 32'd1);

    // Foreign busy in IDLE blocks acceptance.
    step();
    busy_force = 1'b1;
    bus.req_valid = 4'b1111;
    qs = q_id.size();
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.req_ready !== 4'b0000) bad = 1'b1;
    end
    chk("busy blocks ready", 32'(bad), 32'd0);
    chk("busy blocks en", 32'(q_id.size()), 32'(qs));
    bus.req_valid = '0;
    busy_force = 1'b0;
    do_xfer(4'b1111, 4'b1000, 8'h13, 2'd3, 16'd12, "busy release");

    // Asynchronous reset while waiting for the transmitter to finish.
    busy_len = 20;
    step();
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    chk("rwd en", 32'(bus.uart_tx_en), 32'd1);
    n = 0;
    while (!bus.uart_tx_busy && n < 50) begin
      step();
      n++;
    end
    chk("rwd busy seen", 32'(n < 50), 32'd1);
    step();
    chk("rwd active", 32'(bus.grant_active), 32'd1);
    rst = 1'b1;
    #1;
    chk("rwd en", 32'(bus.uart_tx_en), 32'd0);
    chk("rwd data", 32'(bus.uart_tx_data), 32'd0);
    chk("rwd id", 32'(bus.grant_id), 32'd0);
    chk("rwd active", 32'(bus.grant_active), 32'd0);
    chk("rwd stall", 32'(bus.tx_stall_err), 32'd0);
    chk("rwd bytes", 32'(bus.bytes_sent), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    n = 0;
    while (bus.uart_tx_busy && n < 50) begin
      step();
      n++;
    end
    chk("rwd busy end", 32'(n < 50), 32'd1);

    // All valid continuously: order 0,1,2,3,0 spaced by busy time plus four.
    busy_len = 3;
    qs = q_id.size();
    bus.req_valid = 4'b1111;
    #1;
    chk("cont first ready", 32'(bus.req_ready), 32'b0001);
    n = 0;
    while (q_id.size() < qs + 5 && n < 200) begin
      step();
      n++;
    end
    bus.req_valid = '0;
    chk("cont count", 32'(q_id.size() >= qs + 5), 32'd1);
    if (q_id.size() >= qs + 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("cont id%0d", i), 32'(q_id[qs+i]), 32'(i % 4));
        chk($sformatf("cont data%0d", i), 32'(q_data[qs+i]), 32'(8'h10 + (i % 4)));
        if (i > 0) chk($sformatf("cont gap%0d", i), 32'(q_cyc[qs+i] - q_cyc[qs+i-1]), 32'd7);
      end
    end
    n = 0;
    while ((bus.grant_active || bus.uart_tx_busy) && n < 100) begin
      step();
      n++;
    end
    chk("cont bytes", 32'(bus.bytes_sent), 32'd5);

    // Requester 2 sends a three-byte frame while requester 0 stays valid.
    qs = q_id.size();
    cnt2 = 0;
    bus.req_data[23:16] = 8'h21;
    bus.req_last = 4'b1011;
    step();
    bus.req_valid = 4'b0101;
    for (int c = 0; c < 300; c++) begin
      #1;
      pend2 = bus.req_valid[2] & bus.req_ready[2];
      step();
      if (q_id.size() >= qs + 4) break;
      if (pend2) begin
        cnt2++;
        if (cnt2 == 3) begin
          bus.req_valid[2] = 1'b0;
        end else begin
          bus.req_data[23:16] = 8'(8'h21 + cnt2);
          bus.req_last[2]     = (cnt2 == 2);
        end
      end
    end
    bus.req_valid = '0;
    bus.req_last  = '1;
    chk("frame count", 32'(q_id.size() >= qs + 4), 32'd1);
    if (q_id.size() >= qs + 4) begin
`ifdef UART_ARB_FRAME_LOCK_EN
      chk("frame id0", 32'(q_id[qs]),     32'd2);
      chk("frame id1", 32'(q_id[qs+1]),   32'd2);
      chk("frame id2", 32'(q_id[qs+2]),   32'd2);
      chk("frame id3", 32'(q_id[qs+3]),   32'd0);
      chk("frame d1",  32'(q_data[qs+1]), 32'h22);
      chk("frame d2",  32'(q_data[qs+2]), 32'h23);
`else
      chk("frame id0", 32'(q_id[qs]),     32'd2);
      chk("frame id1", 32'(q_id[qs+1]),   32'd0);
      chk("frame id2", 32'(q_id[qs+2]),   32'd2);
      chk("frame id3", 32'(q_id[qs+3]),   32'd0);
      chk("frame d1",  32'(q_data[qs+1]), 32'h10);
      chk("frame d2",  32'(q_data[qs+2]), 32'h22);
`endif
      chk("frame d0", 32'(q_data[qs]),   32'h21);
      chk("frame d3", 32'(q_data[qs+3]), 32'h10);
    end
    n = 0;
    while ((bus.grant_active || bus.uart_tx_busy) && n < 100) begin
      step();
      n++;
    end
    chk("frame bytes", 32'(bus.bytes_sent), 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between NUM_REQ byte producers (e.g. console echo, debug dump, status reporter).
- Arbitrates round-robin, accepts one byte per grant over valid/ready, pulses the transmitter enable, then waits for the transmitter to finish.
- Sits between the requesters and uart_tx.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_WAIT_CYC, 4, max cycles after uart_tx_en for uart_tx_busy to rise before the stall is flagged.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  input  NUM_REQ  per-requester last-byte-of-frame flag (used only with the optional feature).
- req_ready  output  NUM_REQ  per-requester accept strobe.
- uart_tx_busy  input  1  transmitter busy, from uart_tx.
- uart_tx_en  output  1  one-cycle transmit strobe to uart_tx.
- uart_tx_data  output  8  byte to transmit; held stable from the uart_tx_en cycle until return to IDLE.
- grant_id  output  $clog2(NUM_REQ)  index of the requester owning the current byte.
- grant_active  output  1  high from ISSUE through WAIT_DONE.
- tx_stall_err  output  1  sticky; set on busy-rise timeout, cleared only by reset.
- bytes_sent  output  16  count of bytes issued; wraps 0xFFFF -> 0.

Behaviour:
- Reset values: FSM=IDLE, rr pointer=0, uart_tx_en=0, uart_tx_data=0, grant_id=0, grant_active=0, tx_stall_err=0, bytes_sent=0.
- Reset is asynchronous and takes effect mid-operation. A byte already inside uart_tx is not aborted by this block.
- req_ready is combinational:
  - Only the arbitration winner sees ready=1.
  - Only in IDLE with uart_tx_busy=0.
  - A transfer occurs on req_valid[i] & req_ready[i].
- Requesters may drop valid before acceptance; nothing is latched without a transfer.
- Arbitration:
  - Rotating priority starting at the rr pointer.
  - After a grant to i, pointer = (i+1) mod NUM_REQ.
  - All valid continuously -> grant order 0,1,2,3,0,...
- FSM:
  - IDLE: on transfer, latch data and grant_id -> ISSUE. With no valid requester, or uart_tx_busy=1, stay in IDLE.
  - ISSUE: uart_tx_en=1 for exactly this cycle; bytes_sent+=1 -> WAIT_BUSY.
  - WAIT_BUSY: uart_tx_busy=1 -> WAIT_DONE. After BUSY_WAIT_CYC cycles without busy, set tx_stall_err -> IDLE.
  - WAIT_DONE: uart_tx_busy=0 -> IDLE.
- Latency:
  - Accept at cycle t -> uart_tx_en at t+1.
  - Minimum spacing between uart_tx_en pulses is 4 cycles plus the transmitter busy time.
- uart_tx_busy high while in IDLE (another master, or a reset race) blocks acceptance; no ready is given.

Optional Feature:
- Macro: UART_ARB_FRAME_LOCK_EN.
- Defined:
  - After a grant to i without req_last[i], only requester i is eligible (others get ready=0) until a byte with req_last[i]=1 is accepted.
  - The pointer then advances to i+1.
  - grant_id stays at i throughout the frame.
  - Reset clears the lock.
- Undefined: req_last ignored; arbitration is per byte.

Decomposition:
- Package uart_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE);
  - UART_DATA_W=8;
  - BYTES_CNT_W=16.
- Sub-module uart_rr_picker: combinational rotating-priority encoder. Inputs: request vector and pointer. Outputs: one-hot grant and index. It is the natural unit-test target.

Test Plan:
- Single requester: req_valid=4'b0010, data 0xA5, busy model asserts 2 cycles after en for 100 cycles -> req_ready[1] pulse, uart_tx_en one cycle later with uart_tx_data=0xA5, grant_id=1, bytes_sent=1.
- All four valid with data 0x10,0x11,0x12,0x13 -> transmitted order 0x10,0x11,0x12,0x13,0x10; each uart_tx_en separated by the full busy window.
- Busy never rises after en -> tx_stall_err=1 after 4 WAIT_BUSY cycles, FSM returns to IDLE, next request still served, error stays set.
- uart_tx_busy forced high in IDLE with req_valid=4'b1111 -> req_ready=0, no uart_tx_en. Release busy -> grant to rr pointer requester.
- Assert reset during WAIT_DONE -> all outputs to reset values same cycle; after release the first grant goes to requester 0.
- With UART_ARB_FRAME_LOCK_EN: requester 2 sends 3 bytes with last on the 3rd while requester 0 is valid -> bytes 2,2,2 then requester 3 (if valid) else 0. Without the macro -> 2 and 0 interleaved.
